// File: rtl/calc_datapath_if.sv
// Operand, control and result signals of calc_datapath grouped as one bus.
// master drives operands/controls and observes results; slave is the datapath.
interface calc_datapath_if #(
    parameter int unsigned W = 4
);
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [1:0]   s1;
    logic [1:0]   WA;
    logic         WE;
    logic [1:0]   RAA;
    logic [1:0]   RAB;
    logic         REA;
    logic         REB;
    logic [1:0]   C;
    logic         s2;
    logic [W-1:0] out;
    logic         zero;
    logic         ovf;

    modport master (
        output in1, in2, s1, WA, WE, RAA, RAB, REA, REB, C, s2,
        input  out, zero, ovf
    );

    modport slave (
        input  in1, in2, s1, WA, WE, RAA, RAB, REA, REB, C, s2,
        output out, zero, ovf
    );
endinterface

// File: rtl/calc_datapath.sv
// 4-entry register file feeding a 4-op ALU with a registered result, zero and overflow flag.
// Define CALC_DP_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module calc_datapath #(
    parameter int unsigned W = 4
) (
    input logic            clk,
    input logic            rst,
    calc_datapath_if.slave bus
);
    logic [W-1:0] rf_q [4];
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] alu;
    logic [W-1:0] wdata;
    logic [W-1:0] out_q;
    logic         zero_q;

    assign op_a = bus.REA ? rf_q[bus.RAA] : '0;
    assign op_b = bus.REB ? rf_q[bus.RAB] : '0;

    always_comb begin
        alu = '0;
        unique case (bus.C)
            2'b00: alu = op_a + op_b;
            2'b01: alu = op_a - op_b;
            2'b10: alu = op_a & op_b;
            2'b11: alu = op_a ^ op_b;
            default: alu = '0;
        endcase
    end

    always_comb begin
        wdata = '0;
        unique case (bus.s1)
            2'b11: wdata = bus.in1;
            2'b10: wdata = bus.in2;
            2'b01: wdata = alu;
            2'b00: wdata = '0;
            default: wdata = '0;
        endcase
    end

`ifdef CALC_DP_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Overflow when the result sign disagrees with A under sign-compatible operands.
    always_comb begin
        ovf_d = 1'b0;
        unique case (bus.C)
            2'b00: ovf_d = (op_a[W-1] == op_b[W-1]) && (alu[W-1] != op_a[W-1]);
            2'b01: ovf_d = (op_a[W-1] != op_b[W-1]) && (alu[W-1] != op_a[W-1]);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.s2) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    // Write and load both see the pre-edge ALU result, so read-modify-write takes one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            if (bus.WE) begin
                rf_q[bus.WA] <= wdata;
            end
            if (bus.s2) begin
                out_q  <= alu;
                zero_q <= (alu == '0);
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_calc_datapath.sv
// Self-checking bench for calc_datapath: directed scenarios plus randomized cycles
// compared against an arithmetic reference model of the register file and ALU.
module tb_calc_datapath;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk;
    logic rst;

    calc_datapath_if #(.W(W)) bus ();

    calc_datapath #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    int m_rf [4];
    int m_out;
    int m_zero;
    int m_ovf;

`ifdef CALC_DP_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    task automatic ref_alu(input int a, input int b, input int op, output int r, output int v);
        int full;
        int sfull;
        full  = 0;
        sfull = 0;
        case (op)
            0: begin full = a + b; sfull = to_signed(a) + to_signed(b); end
            1: begin full = a - b; sfull = to_signed(a) - to_signed(b); end
            2: begin full = a & b; sfull = 0; end
            default: begin full = a ^ b; sfull = 0; end
        endcase
        r = ((full % M) + M) % M;
        v = (OvfEn && (sfull < -(M / 2) || sfull > (M / 2) - 1)) ? 1 : 0;
    endtask

    // One clock: model sees pre-edge inputs, DUT is sampled at the following falling edge.
    task automatic tick();
        int a, b, r, v, wd;
        a = bus.REA ? m_rf[bus.RAA] : 0;
        b = bus.REB ? m_rf[bus.RAB] : 0;
        ref_alu(a, b, int'(bus.C), r, v);
        case (bus.s1)
            2'd3: wd = int'(bus.in1);
            2'd2: wd = int'(bus.in2);
            2'd1: wd = r;
            default: wd = 0;
        endcase
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_rf[i] = 0;
            m_out  = 0;
            m_zero = 1;
            m_ovf  = 0;
        end else begin
            if (bus.WE) m_rf[bus.WA] = wd;
            if (bus.s2) begin
                m_out  = r;
                m_zero = (r == 0) ? 1 : 0;
                m_ovf  = v;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst     = 1'b0;
        bus.in1 = '0;
        bus.in2 = '0;
        bus.s1  = 2'd0;
        bus.WA  = 2'd0;
        bus.WE  = 1'b0;
        bus.RAA = 2'd0;
        bus.RAB = 2'd0;
        bus.REA = 1'b0;
        bus.REB = 1'b0;
        bus.C   = 2'd0;
        bus.s2  = 1'b0;
    endtask

    task automatic write_reg(input int addr, input int val);
        idle_inputs();
        bus.s1  = 2'd3;
        bus.in1 = W'(val);
        bus.WA  = 2'(addr);
        bus.WE  = 1'b1;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic compute(input int ra, input int rb, input int op);
        idle_inputs();
        bus.RAA = 2'(ra);
        bus.RAB = 2'(rb);
        bus.REA = 1'b1;
        bus.REB = 1'b1;
        bus.C   = 2'(op);
        bus.s2  = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.out !== 4'd0 || bus.zero !== 1'b1 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got out=%0d zero=%0b ovf=%0b, expected out=0 zero=1 ovf=0",
                     bus.out, bus.zero, bus.ovf);
        end
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            bus.RAA = 2'(i);
            bus.REA = 1'b1;
            bus.s2  = 1'b1;
            tick();
            n_checks++;
            if (bus.out !== 4'd0 || bus.zero !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_rf%0d: got out=%0d zero=%0b, expected out=0 zero=1",
                         i, bus.out, bus.zero);
            end
        end
    endtask

    task automatic test_load();
        idle_inputs();
        bus.s1 = 2'd3; bus.in1 = 4'd5; bus.WE = 1'b1; bus.WA = 2'd1;
        tick();
        idle_inputs();
        bus.s1 = 2'd2; bus.in2 = 4'd3; bus.WE = 1'b1; bus.WA = 2'd2;
        tick();
        compute(1, 2, 0);
        n_checks++;
        if (bus.out !== 4'd8 || bus.zero !== 1'b0 || int'(bus.out) != m_out) begin
            n_fail++;
            $display("FAIL load_add: got out=%0d zero=%0b, expected out=8 zero=0",
                     bus.out, bus.zero);
        end
        // Hold with s2=0 while operands change.
        idle_inputs();
        bus.RAA = 2'd1; bus.REA = 1'b1; bus.C = 2'd3;
        tick();
        n_checks++;
        if (bus.out !== 4'd8) begin
            n_fail++;
            $display("FAIL load_hold: got out=%0d, expected 8", bus.out);
        end
    endtask

    task automatic test_ops();
        int exp_v [4];
        exp_v = '{2, 1, 6, 5};
        for (int op = 1; op < 4; op++) begin
            compute(1, 2, op);
            n_checks++;
            if (int'(bus.out) != exp_v[op - 1] || int'(bus.out) != m_out) begin
                n_fail++;
                $display("FAIL ops_c%0d: got %0d, expected %0d", op, bus.out, exp_v[op - 1]);
            end
        end
        idle_inputs();
        bus.RAA = 2'd1; bus.RAB = 2'd2; bus.REA = 1'b1; bus.REB = 1'b0; bus.s2 = 1'b1;
        tick();
        n_checks++;
        if (int'(bus.out) != exp_v[3]) begin
            n_fail++;
            $display("FAIL ops_reb0: got %0d, expected %0d", bus.out, exp_v[3]);
        end
    endtask

    task automatic test_wrap_writeback();
        write_reg(1, 15);
        write_reg(2, 1);
        write_reg(3, 9);
        compute(1, 2, 0);
        n_checks++;
        if (bus.out !== 4'd0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_add: got out=%0d zero=%0b, expected out=0 zero=1",
                     bus.out, bus.zero);
        end
        // ALU writeback into R3 in the same cycle as the load.
        idle_inputs();
        bus.RAA = 2'd1; bus.RAB = 2'd2; bus.REA = 1'b1; bus.REB = 1'b1;
        bus.s1 = 2'd1; bus.WE = 1'b1; bus.WA = 2'd3; bus.s2 = 1'b1;
        tick();
        // Read R3 while overwriting it: must see the writeback value 0, not 4.
        idle_inputs();
        bus.RAA = 2'd3; bus.REA = 1'b1; bus.s2 = 1'b1;
        bus.s1 = 2'd3; bus.in1 = 4'd4; bus.WE = 1'b1; bus.WA = 2'd3;
        tick();
        n_checks++;
        if (bus.out !== 4'd0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_old_value: got out=%0d, expected 0", bus.out);
        end
        idle_inputs();
        bus.RAA = 2'd3; bus.RAB = 2'd3; bus.REA = 1'b1; bus.REB = 1'b1; bus.s2 = 1'b1;
        tick();
        n_checks++;
        if (bus.out !== 4'd8 || int'(bus.out) != m_out) begin
            n_fail++;
            $display("FAIL wb_new_value: got out=%0d, expected 8 (R3=4 on both ports)", bus.out);
        end
    endtask

    task automatic test_ovf();
        write_reg(1, 7);
        write_reg(2, 1);
        compute(1, 2, 0);
        n_checks++;
        if (bus.out !== 4'd8 || bus.ovf !== OvfEn) begin
            n_fail++;
            $display("FAIL ovf_add: got out=%0d ovf=%0b, expected out=8 ovf=%0b",
                     bus.out, bus.ovf, OvfEn);
        end
        write_reg(1, 8);
        compute(1, 2, 1);
        n_checks++;
        if (bus.out !== 4'd7 || bus.ovf !== OvfEn) begin
            n_fail++;
            $display("FAIL ovf_sub: got out=%0d ovf=%0b, expected out=7 ovf=%0b",
                     bus.out, bus.ovf, OvfEn);
        end
        compute(1, 2, 2);
        n_checks++;
        if (bus.out !== 4'd0 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_and: got out=%0d ovf=%0b, expected out=0 ovf=0", bus.out, bus.ovf);
        end
    endtask

    task automatic test_reset_mid();
        write_reg(0, 6);
        write_reg(1, 3);
        compute(0, 1, 0);
        idle_inputs();
        rst = 1'b1; bus.WE = 1'b1; bus.s1 = 2'd3; bus.in1 = 4'd11; bus.WA = 2'd2;
        bus.RAA = 2'd0; bus.RAB = 2'd1; bus.REA = 1'b1; bus.REB = 1'b1; bus.s2 = 1'b1;
        tick();
        n_checks++;
        if (bus.out !== 4'd0 || bus.zero !== 1'b1 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_out: got out=%0d zero=%0b ovf=%0b, expected 0/1/0",
                     bus.out, bus.zero, bus.ovf);
        end
        write_reg(3, 5);
        n_checks++;
        if (bus.out !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid_hold: got out=%0d, expected 0", bus.out);
        end
        for (int i = 0; i < 3; i++) begin
            compute(i, 3, 0);
            n_checks++;
            if (bus.out !== 4'd5) begin
                n_fail++;
                $display("FAIL rst_mid_rf%0d: got out=%0d, expected 5 (R%0d cleared)",
                         i, bus.out, i);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst     = ($urandom_range(0, 29) == 0);
            bus.in1 = W'($urandom);
            bus.in2 = W'($urandom);
            bus.s1  = 2'($urandom);
            bus.WA  = 2'($urandom);
            bus.WE  = 1'($urandom);
            bus.RAA = 2'($urandom);
            bus.RAB = 2'($urandom);
            bus.REA = ($urandom_range(0, 3) != 0);
            bus.REB = ($urandom_range(0, 3) != 0);
            bus.C   = 2'($urandom);
            bus.s2  = 1'($urandom);
            tick();
            n_checks++;
            if (int'(bus.out) != m_out || int'(bus.zero) != m_zero || int'(bus.ovf) != m_ovf) begin
                n_fail++;
                $display("FAIL random_%0d: got out=%0d zero=%0b ovf=%0b, expected %0d/%0d/%0d",
                         n, bus.out, bus.zero, bus.ovf, m_out, m_zero, m_ovf);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        m_out  = 0;
        m_zero = 1;
        m_ovf  = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load();
        test_ops();
        test_wrap_writeback();
        test_ovf();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_datapath.md
CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 Parameter: W, 4, data width in bits of inputs, register-file entries, ALU and output.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in1  input  W  external operand A.
REQ-005 Port: in2  input  W  external operand B.
REQ-006 Port: s1  input  2  write-data mux select: 3=in1, 2=in2, 1=ALU result, 0=zero.
REQ-007 Port: WA  input  2  register-file write address.
REQ-008 Port: WE  input  1  register-file write enable.
REQ-009 Port: RAA  input  2  read address, port A.
REQ-010 Port: RAB  input  2  read address, port B.
REQ-011 Port: REA  input  1  read enable A; when 0, port A drives zero.
REQ-012 Port: REB  input  1  read enable B; when 0, port B drives zero.
REQ-013 Port: C  input  2  ALU op: 00 add, 01 sub (A-B), 10 AND, 11 XOR.
REQ-014 Port: s2  input  1  output-register load enable.
REQ-015 Port: out  output  W  registered result.
REQ-016 Port: zero  output  1  registered: out == 0.
REQ-017 Port: ovf  output  1  registered signed-overflow flag (see Configuration).

Function
REQ-018 Register file SHALL hold 4 entries of W bits; write SHALL occur at rising clk when WE=1, to entry WA, with the s1-selected value.
REQ-019 Read ports SHALL be combinational: A = REA ? RF[RAA] : 0, B = REB ? RF[RAB] : 0.
REQ-020 Read and write of the same address in one cycle SHALL return the old (pre-edge) value; no bypass.
REQ-021 RAA == RAB SHALL be legal; both ports return the same entry.
REQ-022 ALU SHALL be combinational on A, B, C; result truncated to W bits (add/sub wrap modulo 2^W, carry/borrow discarded).
REQ-023 Write and output load in one cycle SHALL both use the ALU result computed from pre-edge register contents; a read-compute-writeback completes in one clock.
REQ-024 out SHALL load the ALU result at rising clk when s2=1 and hold when s2=0; latency from operand change to out is one clock.
REQ-025 zero SHALL update at the same edge as out, reflecting the newly loaded value, and hold when s2=0.
REQ-026 WE=0 SHALL leave all entries unchanged regardless of s1/WA.
REQ-027 No combinational path SHALL exist from any input to out, zero or ovf.

Reset
REQ-028 rst=1 at rising clk SHALL clear all 4 RF entries to 0, out to 0, ovf to 0, and set zero to 1.
REQ-029 rst SHALL take priority over WE and s2 in the same cycle; write and load are discarded.
REQ-030 After rst deasserts, the first edge SHALL operate normally with no extra delay.

Configuration
REQ-031 Macro CALC_DP_OVF_EN: when defined, ovf SHALL load with out (s2=1) as two's-complement overflow of add (same-sign operands, result sign differs) or sub (different-sign operands, result sign differs from A); 0 for AND/XOR.
REQ-032 When CALC_DP_OVF_EN is undefined, ovf SHALL be tied to constant 0 and no overflow logic synthesized; all other behaviour identical.

Verification
REQ-033 Reset: rst=1 one edge -> out=0, zero=1, ovf=0; read RF[0..3] with REA=1 via add with REB=0 -> all 0.
REQ-034 Load: s1=3, in1=5, WE=1, WA=1; then s1=2, in2=3, WA=2; then RAA=1, RAB=2, REA=REB=1, C=00, s2=1 -> out=8, zero=0.
REQ-035 Ops on R1=5, R2=3: C=01 -> out=2; C=10 -> out=1; C=11 -> out=6; REB=0, C=00 -> out=5.
REQ-036 Wrap/writeback: R1=0xF, R2=1, C=00, s1=1, WE=1, WA=3, s2=1 -> out=0, zero=1, R3=0 next cycle; same-cycle read of R3 returns old value.
REQ-037 Overflow (macro defined): R1=7, R2=1, C=00, s2=1 -> out=8, ovf=1; R1=8, R2=1, C=01 -> out=7, ovf=1; macro undefined -> ovf=0 in both.
REQ-038 Reset mid-operation: WE=1, s2=1, rst=1 same edge -> RF unchanged from 0, out=0; s2=0 afterwards -> out holds.
